// File: rtl/au_rr_arbiter.sv
// Round-robin arbiter granting one shared arithmetic resource to WIDTH requesters.
// A grant is held until the resource reports done; the served requester then drops to lowest priority.
module au_rr_arbiter #(
    parameter int WIDTH = 4,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    ptr, ptr_n, ptr_inc, base;
    logic [WIDTH-1:0] gnt_n, pick_gnt;
    logic [IW-1:0]    idx_n, pick_idx;
    logic             pick_found;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            ptr     <= ptr_n;
        end
    end

    assign busy    = (state == BUSY);
    assign ptr_inc = (gnt_idx == IW'(WIDTH - 1)) ? '0 : gnt_idx + IW'(1);

    // On completion the search starts just past the served requester.
    assign base = (state == BUSY) ? ptr_inc : ptr;

    always_comb begin
        int            k;
        logic [IW-1:0] kk;
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        k          = 0;
        kk         = '0;
        pick_found = 1'b0;
        pick_gnt   = '0;
        pick_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            k = int'(base) + i;
            if (k >= WIDTH) k = k - WIDTH;
            kk = IW'(k);
            if (!pick_found && req[kk]) begin
                pick_found   = 1'b1;
                pick_gnt[kk] = 1'b1;
                pick_idx     = kk;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_found) state_n = BUSY;
            BUSY:    if (done && !pick_found) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gnt_n = gnt;
        idx_n = gnt_idx;
        ptr_n = ptr;
        case (state)
            IDLE: begin
                gnt_n = pick_gnt;
                idx_n = pick_idx;
            end
            BUSY: begin
                if (done) begin
                    ptr_n = ptr_inc;
                    gnt_n = pick_gnt;
                    idx_n = pick_idx;
                end
            end
            default: begin
                gnt_n = '0;
                idx_n = '0;
                ptr_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_au_rr_arbiter.sv
// Directed bench for au_rr_arbiter: a 4-wide instance and a 3-wide (non-power-of-two) instance.
module tb_au_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req4;
    logic       done4;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       busy4;
    logic [2:0] req3;
    logic       done3;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    au_rr_arbiter #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .req(req4), .done(done4),
        .gnt(gnt4), .gnt_idx(idx4), .busy(busy4)
    );

    au_rr_arbiter #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .req(req3), .done(done3),
        .gnt(gnt3), .gnt_idx(idx3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] i, input logic b);
        check({tag, ".gnt"}, 32'(gnt4), 32'(g));
        check({tag, ".idx"}, 32'(idx4), 32'(i));
        check({tag, ".busy"}, 32'(busy4), 32'(b));
    endtask

    task automatic chk3(input string tag, input logic [2:0] g, input logic [1:0] i, input logic b);
        check({tag, ".gnt3"}, 32'(gnt3), 32'(g));
        check({tag, ".idx3"}, 32'(idx3), 32'(i));
        check({tag, ".busy3"}, 32'(busy3), 32'(b));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req4 = '0; done4 = 1'b0; req3 = '0; done3 = 1'b0;
        #2;
        chk4("rst_async4", 4'b0000, 2'd0, 1'b0);
        chk3("rst_async3", 3'b000, 2'd0, 1'b0);
        step(); step();
        rst = 1'b0;

        step();
        chk4("idle_noreq", 4'b0000, 2'd0, 1'b0);
        done4 = 1'b1;
        step();
        chk4("idle_done_ignored", 4'b0000, 2'd0, 1'b0);
        done4 = 1'b0;

        req4 = 4'b1111;
        step();
        chk4("contend_first", 4'b0001, 2'd0, 1'b1);

        done4 = 1'b1;
        step(); chk4("rot_1", 4'b0010, 2'd1, 1'b1);
        step(); chk4("rot_2", 4'b0100, 2'd2, 1'b1);
        step(); chk4("rot_3", 4'b1000, 2'd3, 1'b1);
        step(); chk4("rot_0", 4'b0001, 2'd0, 1'b1);
        done4 = 1'b0;
        step(); chk4("rot_hold", 4'b0001, 2'd0, 1'b1);

        req4 = 4'b1000; done4 = 1'b1;
        step(); chk4("grant_3", 4'b1000, 2'd3, 1'b1);
        req4 = 4'b0000; done4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(); chk4("hold_withdrawn", 4'b1000, 2'd3, 1'b1);
        end
        done4 = 1'b1;
        step(); chk4("release_idle", 4'b0000, 2'd0, 1'b0);
        done4 = 1'b0; req4 = 4'b0101;
        step(); chk4("wrap_ptr0", 4'b0001, 2'd0, 1'b1);

        req4 = 4'b0100; done4 = 1'b1;
        step(); chk4("grant_2", 4'b0100, 2'd2, 1'b1);
        step(); chk4("sole_regrant", 4'b0100, 2'd2, 1'b1);
        req4 = 4'b1111;
        step(); chk4("after_sole_ptr3", 4'b1000, 2'd3, 1'b1);
        req4 = 4'b1001;
        step(); chk4("served_lowest", 4'b0001, 2'd0, 1'b1);

        req4 = 4'b0010;
        step(); chk4("grant_1", 4'b0010, 2'd1, 1'b1);
        step(); chk4("grant_1_again", 4'b0010, 2'd1, 1'b1);
        done4 = 1'b0;
        step(); chk4("hold_1", 4'b0010, 2'd1, 1'b1);
        #3 rst = 1'b1;
        #1 chk4("rst_mid_grant", 4'b0000, 2'd0, 1'b0);
        req4 = 4'b1111; done4 = 1'b1;
        step(); step();
        chk4("rst_held_edges", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req4 = 4'b1010; done4 = 1'b0;
        step(); chk4("post_rst_ptr0", 4'b0010, 2'd1, 1'b1);

        req3 = 3'b111;
        step(); chk3("w3_0", 3'b001, 2'd0, 1'b1);
        done3 = 1'b1;
        step(); chk3("w3_1", 3'b010, 2'd1, 1'b1);
        step(); chk3("w3_2", 3'b100, 2'd2, 1'b1);
        step(); chk3("w3_wrap0", 3'b001, 2'd0, 1'b1);
        req3 = 3'b000;
        step(); chk3("w3_idle", 3'b000, 2'd0, 1'b0);
        done3 = 1'b0; req3 = 3'b101;
        step(); chk3("w3_ptr1", 3'b100, 2'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
